alu_exec_unit: RTL and testbench

Execute stage of the 16-bit CPU, directly downstream of the register file's operand outputs and upstream of its write port. Accepts one operation per valid/ready handshake (opcode, two 16-bit operands, 3-bit destination), computes the result, and drives the register file write interface (`Reg_data`, `Reg_addr`, `Reg_load`) with a one-cycle write pulse. Single-cycle ops sustain one op per clock. MUL is an iterative shift-add taking 16 extra cycles and back-pressures upstream while running.

---
 rtl/alu_exec_unit.sv | 156 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute stage of the 16-bit CPU: single-cycle ALU ops plus an iterative
// shift-add multiplier, driving the register file write port with one-cycle pulses.
module alu_exec_unit #(
  parameter int WIDTH      = 16,
  parameter int ADDR_W     = 3,
  parameter int MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic [WIDTH-1:0]  Reg_data,
  output logic [ADDR_W-1:0] Reg_addr,
  output logic              Reg_load,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              busy
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t              state_r;
  logic [2*WIDTH-1:0]  mcand_r;
  logic [WIDTH-1:0]    mplier_r;
  logic [2*WIDTH-1:0]  acc_r;
  logic [CNT_W-1:0]    count_r;
  logic [ADDR_W-1:0]   dest_r;

  logic [WIDTH:0]      sum_s;
  logic [2*WIDTH-1:0]  shl_s;
  logic [WIDTH-1:0]    alu_res_s;
  logic                alu_carry_s;
  logic [2*WIDTH-1:0]  acc_next_s;

  assign in_ready = (state_r == IDLE) && !rst;

  // Single-cycle ALU result and carry for the presented opcode
  always_comb begin
    sum_s       = {1'b0, op1} + {1'b0, op2};
    shl_s       = {{WIDTH{1'b0}}, op1} << op2[3:0];
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        alu_res_s   = op1 - op2;
        alu_carry_s = (op1 < op2);
      end
      OP_AND:  alu_res_s = op1 & op2;
      OP_OR:   alu_res_s = op1 | op2;
      OP_XOR:  alu_res_s = op1 ^ op2;
      // bit WIDTH of the widened shift is the last bit pushed out (0 for a zero shift)
      OP_SHL: begin
        alu_res_s   = shl_s[WIDTH-1:0];
        alu_carry_s = shl_s[WIDTH];
      end
      OP_PASS: alu_res_s = op2;
      default: begin
        alu_res_s   = {WIDTH{1'b0}};
        alu_carry_s = 1'b0;
      end
    endcase
  end

  // Partial-product accumulation for the current multiply iteration
  always_comb begin
    acc_next_s = acc_r;
    case (mplier_r[0])
      1'b1:    acc_next_s = acc_r + mcand_r;
      default: acc_next_s = acc_r;
    endcase
  end

  // Control state, multiplier datapath and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      mcand_r    <= {(2*WIDTH){1'b0}};
      mplier_r   <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      count_r    <= {CNT_W{1'b0}};
      dest_r     <= {ADDR_W{1'b0}};
      Reg_data   <= {WIDTH{1'b0}};
      Reg_addr   <= {ADDR_W{1'b0}};
      Reg_load   <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      busy       <= 1'b0;
    end else begin
      Reg_load <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (opcode == OP_MUL) begin
              mcand_r  <= {{WIDTH{1'b0}}, op1};
              mplier_r <= op2;
              acc_r    <= {(2*WIDTH){1'b0}};
              count_r  <= {CNT_W{1'b0}};
              dest_r   <= dest_addr;
              busy     <= 1'b1;
              state_r  <= MUL;
            end else begin
              Reg_data   <= alu_res_s;
              Reg_addr   <= dest_addr;
              zero_flag  <= (alu_res_s == {WIDTH{1'b0}});
              carry_flag <= alu_carry_s;
              Reg_load   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CNT_W'(1);
          if (count_r == LAST_CNT) begin
            Reg_data   <= acc_next_s[WIDTH-1:0];
            Reg_addr   <= dest_r;
            zero_flag  <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            carry_flag <= (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            Reg_load   <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  opcode = 3'd0;
  logic [15:0] op1 = 16'd0;
  logic [15:0] op2 = 16'd0;
  logic [2:0]  dest_addr = 3'd0;
  logic        in_ready;
  logic [15:0] Reg_data;
  logic [2:0]  Reg_addr;
  logic        Reg_load;
  logic        zero_flag;
  logic        carry_flag;
  logic        busy;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(16), .ADDR_W(3), .MUL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .dest_addr(dest_addr),
    .Reg_data(Reg_data), .Reg_addr(Reg_addr), .Reg_load(Reg_load),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: results straight from the opcode table using integer arithmetic
  function automatic void model(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output logic cy);
    int unsigned ua, ub, p, sh;
    ua = 32'(a);
    ub = 32'(b);
    p = 0;
    sh = 0;
    res = 16'd0;
    cy = 1'b0;
    case (opc)
      3'd0: begin p = ua + ub; res = 16'(p % 65536); cy = (p > 65535); end
      3'd1: begin res = 16'((ua + 65536 - ub) % 65536); cy = (ua < ub); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: begin
        sh = ub % 16;
        p = ua * (32'd1 << sh);
        res = 16'(p % 65536);
        cy = (sh != 0) && (((ua >> (16 - sh)) % 2) == 1);
      end
      3'd6: begin p = ua * ub; res = 16'(p % 65536); cy = (p > 65535); end
      default: res = b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode = opc;
    op1 = a;
    op2 = b;
    dest_addr = d;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d, input string tag);
    logic [15:0] er;
    logic ec;
    int k;
    model(opc, a, b, er, ec);
    issue(opc, a, b, d);
    if (opc == 3'd6) in_valid = 1'b0;
    k = 0;
    while (!Reg_load && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), (opc == 3'd6) ? 32'd16 : 32'd0);
    chk({tag, "_load"}, 32'(Reg_load), 32'd1);
    chk({tag, "_data"}, 32'(Reg_data), 32'(er));
    chk({tag, "_addr"}, 32'(Reg_addr), 32'(d));
    chk({tag, "_zero"}, 32'(zero_flag), (er == 16'd0) ? 32'd1 : 32'd0);
    chk({tag, "_carry"}, 32'(carry_flag), 32'(ec));
  endtask

  initial begin
    logic [2:0]  r_opc;
    logic [15:0] r_a, r_b;
    int seen;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(Reg_data), 32'd0);
    chk("rst_addr", 32'(Reg_addr), 32'd0);
    chk("rst_load", 32'(Reg_load), 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_carry", 32'(carry_flag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    run_op(3'd0, 16'hFFFF, 16'h0001, 3'd3, "add_wrap");
    chk("add_wrap_const", 32'(Reg_data), 32'h0000);

    run_op(3'd1, 16'd10, 16'd100, 3'd0, "sub_borrow");
    chk("sub_const", 32'(Reg_data), 32'hFFA6);
    run_op(3'd4, 16'h00FF, 16'h0F0F, 3'd2, "xor_b2b");
    chk("xor_const", 32'(Reg_data), 32'h0FF0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_no_load", 32'(Reg_load), 32'd0);
    chk("idle_hold_data", 32'(Reg_data), 32'h0FF0);

    // MUL with a second op held on the input throughout
    issue(3'd6, 16'd500, 16'd10, 3'd5);
    opcode = 3'd0;
    op1 = 16'd7;
    op2 = 16'd8;
    dest_addr = 3'd1;
    for (int i = 0; i < 16; i++) begin
      chk("mul_ready_low", 32'(in_ready), 32'd0);
      chk("mul_busy", 32'(busy), 32'd1);
      chk("mul_no_early_load", 32'(Reg_load), 32'd0);
      @(negedge clk);
    end
    chk("mul_load", 32'(Reg_load), 32'd1);
    chk("mul_data", 32'(Reg_data), 32'h1388);
    chk("mul_carry", 32'(carry_flag), 32'd0);
    chk("mul_addr", 32'(Reg_addr), 32'd5);
    chk("mul_ready_back", 32'(in_ready), 32'd1);
    chk("mul_busy_clear", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_add_load", 32'(Reg_load), 32'd1);
    chk("held_add_data", 32'(Reg_data), 32'd15);
    chk("held_add_addr", 32'(Reg_addr), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_add_once", 32'(Reg_load), 32'd0);

    run_op(3'd6, 16'd1000, 16'd100, 3'd4, "mul_ovf");
    chk("mul_ovf_const", 32'(Reg_data), 32'h86A0);
    run_op(3'd6, 16'h1234, 16'h0000, 3'd6, "mul_zero");
    run_op(3'd5, 16'h8001, 16'h0001, 3'd1, "shl_one");
    chk("shl_const", 32'(Reg_data), 32'h0002);
    run_op(3'd5, 16'h1234, 16'h0010, 3'd2, "shl_zero");
    chk("shl_zero_const", 32'(Reg_data), 32'h1234);
    run_op(3'd7, 16'h5555, 16'h2710, 3'd7, "pass");
    chk("pass_const", 32'(Reg_data), 32'h2710);

    for (int n = 0; n < 80; n++) begin
      r_opc = 3'($urandom_range(0, 7));
      r_a = 16'($urandom);
      r_b = 16'($urandom);
      if ($urandom_range(0, 5) == 0) r_b = 16'(r_a);
      if ($urandom_range(0, 7) == 0) r_a = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      run_op(r_opc, r_a, r_b, 3'($urandom_range(0, 7)), "rand");
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a multiply aborts it
    run_op(3'd7, 16'h0000, 16'hBEEF, 3'd7, "pre_abort");
    in_valid = 1'b0;
    @(negedge clk);
    issue(3'd6, 16'd1000, 16'd100, 3'd6);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_data", 32'(Reg_data), 32'd0);
    chk("abort_addr", 32'(Reg_addr), 32'd0);
    chk("abort_load", 32'(Reg_load), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_zero", 32'(zero_flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (Reg_load) seen++;
      @(negedge clk);
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    run_op(3'd0, 16'h1111, 16'h2222, 3'd3, "add_after_rst");
    chk("add_after_rst_const", 32'(Reg_data), 32'h3333);
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
